// File: rtl/pi_pkg.sv
// Shared definitions for the PI loop controller: FSM state encoding and default output bounds.
package pi_pkg;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_WAIT_ADC  = 3'd1,
        ST_COMPUTE   = 3'd2,
        ST_SATURATE  = 3'd3,
        ST_DAC_WRITE = 3'd4
    } pi_state_t;

    localparam logic signed [31:0] DEF_SAT_LOWER    = -32'sh80000;
    localparam logic signed [31:0] DEF_SAT_UPPER    = 32'sh7FFFF;
    localparam logic signed [31:0] DEF_INTEGRAL_MAX = 32'sh7FFFFFFF;

endpackage

// File: rtl/pi_loop_controller_clamp.sv
// Combinational signed clamp of a value into [i_lower, i_upper].
module signed_clamp #(
    parameter int WIDTH = 32
) (
    input  logic signed [WIDTH-1:0] i_value,
    input  logic signed [WIDTH-1:0] i_lower,
    input  logic signed [WIDTH-1:0] i_upper,
    output logic signed [WIDTH-1:0] o_value
);

    always_comb begin
        o_value = i_value;
        if (i_value < i_lower) begin
            o_value = i_lower;
        end else if (i_value > i_upper) begin
            o_value = i_upper;
        end
    end

endmodule

// File: rtl/pi_loop_controller.sv
// PI loop sequencer: takes an ADC sample, drives an external PI pipeline, clamps the
// result and writes it to the DAC.
//
// state        | meaning
// ST_IDLE      | loop disabled
// ST_WAIT_ADC  | adc_ready high, waiting for a sample
// ST_COMPUTE   | external pipeline running, down-counter timing its latency
// ST_SATURATE  | clamp captured PI result into dac_data
// ST_DAC_WRITE | dac_valid high until the DAC accepts
module pi_loop_controller
    import pi_pkg::*;
#(
    parameter int                 INPUT_WIDTH  = 18,
    parameter int                 OUTPUT_WIDTH = 32,
    parameter int                 DAC_WIDTH    = 20,
    parameter int                 PIPE_LATENCY = 5,
    parameter logic signed [31:0] SAT_LOWER    = DEF_SAT_LOWER,
    parameter logic signed [31:0] SAT_UPPER    = DEF_SAT_UPPER,
    parameter logic signed [31:0] INTEGRAL_MAX = DEF_INTEGRAL_MAX
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    enable,
    input  logic                    integral_clear,
    input  logic                    adc_valid,
    input  logic [INPUT_WIDTH-1:0]  adc_data,
    output logic                    adc_ready,
    output logic [INPUT_WIDTH-1:0]  pipe_actual,
    output logic [OUTPUT_WIDTH-1:0] pipe_integral_input,
    input  logic [OUTPUT_WIDTH-1:0] pipe_integral_result,
    input  logic [OUTPUT_WIDTH-1:0] pipe_pi_result,
    output logic                    dac_valid,
    output logic [DAC_WIDTH-1:0]    dac_data,
    input  logic                    dac_ready,
    output logic [31:0]             sample_count,
    output logic [31:0]             sat_count,
    output logic                    busy
);

    localparam int CNT_W = $clog2(PIPE_LATENCY + 1) + 1;
    localparam logic signed [OUTPUT_WIDTH-1:0] OUT_LO = OUTPUT_WIDTH'(SAT_LOWER);
    localparam logic signed [OUTPUT_WIDTH-1:0] OUT_HI = OUTPUT_WIDTH'(SAT_UPPER);
    localparam logic signed [OUTPUT_WIDTH-1:0] INT_HI = OUTPUT_WIDTH'(INTEGRAL_MAX);
    localparam logic signed [OUTPUT_WIDTH-1:0] INT_LO = -INT_HI;

    pi_state_t                 r_state;
    pi_state_t                 w_next;
    logic [CNT_W-1:0]          r_cnt;
    logic [OUTPUT_WIDTH-1:0]   r_pi;
    logic [INPUT_WIDTH-1:0]    r_actual;
    logic [OUTPUT_WIDTH-1:0]   r_integral;
    logic [DAC_WIDTH-1:0]      r_dac_data;
    logic [31:0]               r_sample_count;
    logic [31:0]               r_sat_count;
    logic                      w_adc_hs;
    logic                      w_dac_hs;
    logic                      w_capture;
    logic                      w_out_sat;
    logic signed [OUTPUT_WIDTH-1:0] w_int_clamped;
    logic signed [OUTPUT_WIDTH-1:0] w_out_clamped;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next    = r_state;
        adc_ready = 1'b0;
        dac_valid = 1'b0;
        busy      = (r_state != ST_IDLE);
        case (r_state)
            ST_IDLE: begin
                if (enable) w_next = ST_WAIT_ADC;
            end
            ST_WAIT_ADC: begin
                adc_ready = enable;
                if (!enable)        w_next = ST_IDLE;
                else if (adc_valid) w_next = ST_COMPUTE;
            end
            ST_COMPUTE: begin
                if (!enable)                w_next = ST_IDLE;
                else if (r_cnt == '0)       w_next = ST_SATURATE;
            end
            ST_SATURATE: begin
                w_next = ST_DAC_WRITE;
            end
            ST_DAC_WRITE: begin
                dac_valid = 1'b1;
                // A pending write always completes; enable is only honoured afterwards.
                if (dac_ready) w_next = enable ? ST_WAIT_ADC : ST_IDLE;
            end
            default: w_next = ST_IDLE;
        endcase
    end

    assign w_adc_hs  = adc_valid && adc_ready;
    assign w_dac_hs  = dac_valid && dac_ready;
    assign w_capture = (r_state == ST_COMPUTE) && enable && (r_cnt == '0);
    assign w_out_sat = (w_out_clamped != r_pi);

    signed_clamp #(.WIDTH(OUTPUT_WIDTH)) u_int_clamp (
        .i_value (pipe_integral_result),
        .i_lower (INT_LO),
        .i_upper (INT_HI),
        .o_value (w_int_clamped)
    );

    signed_clamp #(.WIDTH(OUTPUT_WIDTH)) u_out_clamp (
        .i_value (r_pi),
        .i_lower (OUT_LO),
        .i_upper (OUT_HI),
        .o_value (w_out_clamped)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt          <= '0;
            r_pi           <= '0;
            r_actual       <= '0;
            r_integral     <= '0;
            r_dac_data     <= '0;
            r_sample_count <= '0;
            r_sat_count    <= '0;
        end else begin
            if (w_adc_hs) begin
                r_actual <= adc_data;
                r_cnt    <= CNT_W'(PIPE_LATENCY);
            end else if ((r_state == ST_COMPUTE) && (r_cnt != '0)) begin
                r_cnt <= r_cnt - CNT_W'(1);
            end
            if (w_capture) r_pi <= pipe_pi_result;
            if (integral_clear) begin
                r_integral <= '0;
            end else if (w_capture) begin
                r_integral <= w_int_clamped;
            end
            if (r_state == ST_SATURATE) begin
                r_dac_data <= w_out_clamped[DAC_WIDTH-1:0];
                if (w_out_sat) r_sat_count <= r_sat_count + 32'd1;
            end
            if (w_dac_hs) r_sample_count <= r_sample_count + 32'd1;
        end
    end

    assign pipe_actual         = r_actual;
    assign pipe_integral_input = r_integral;
    assign dac_data            = r_dac_data;
    assign sample_count        = r_sample_count;
    assign sat_count           = r_sat_count;

endmodule

// File: tb/tb_pi_loop_controller.sv
// Directed bench for pi_loop_controller with a stand-in PI pipeline and a transaction-level model.
module tb_pi_loop_controller;

    localparam int IW = 18;
    localparam int OW = 32;
    localparam int DW = 20;
    localparam int PL = 5;
    localparam logic signed [31:0] IMAX = 32'sd25;
    localparam logic signed [31:0] SLO  = -32'sh80000;
    localparam logic signed [31:0] SHI  = 32'sh7FFFF;

    logic          clk;
    logic          rst_n;
    logic          enable;
    logic          integral_clear;
    logic          adc_valid;
    logic [IW-1:0] adc_data;
    logic          adc_ready;
    logic [IW-1:0] pipe_actual;
    logic [OW-1:0] pipe_integral_input;
    logic [OW-1:0] pipe_integral_result;
    logic [OW-1:0] pipe_pi_result;
    logic          dac_valid;
    logic [DW-1:0] dac_data;
    logic          dac_ready;
    logic [31:0]   sample_count;
    logic [31:0]   sat_count;
    logic          busy;

    pi_loop_controller #(.INTEGRAL_MAX(IMAX)) dut (
        .clk                  (clk),
        .rst_n                (rst_n),
        .enable               (enable),
        .integral_clear       (integral_clear),
        .adc_valid            (adc_valid),
        .adc_data             (adc_data),
        .adc_ready            (adc_ready),
        .pipe_actual          (pipe_actual),
        .pipe_integral_input  (pipe_integral_input),
        .pipe_integral_result (pipe_integral_result),
        .pipe_pi_result       (pipe_pi_result),
        .dac_valid            (dac_valid),
        .dac_data             (dac_data),
        .dac_ready            (dac_ready),
        .sample_count         (sample_count),
        .sat_count            (sat_count),
        .busy                 (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Stand-in for the parent's pipeline: err = actual - setpoint, integral += ki*err,
    // pi = kp*err + integral, delivered PL cycles later.
    logic signed [31:0] kp, ki, setpoint;
    logic signed [IW-1:0] st_act;
    logic signed [31:0] st_err, st_int, st_pi;
    logic signed [31:0] pl_pi [PL];
    logic signed [31:0] pl_int [PL];

    always_comb begin
        st_act = pipe_actual;
        st_err = {{(32-IW){st_act[IW-1]}}, st_act} - setpoint;
        st_int = pipe_integral_input + ki * st_err;
        st_pi  = kp * st_err + st_int;
    end

    always @(posedge clk) begin
        pl_pi[0]  <= st_pi;
        pl_int[0] <= st_int;
        for (int i = 1; i < PL; i++) begin
            pl_pi[i]  <= pl_pi[i-1];
            pl_int[i] <= pl_int[i-1];
        end
    end

    assign pipe_pi_result       = pl_pi[PL-1];
    assign pipe_integral_result = pl_int[PL-1];

    function automatic logic signed [31:0] clampf(input logic signed [31:0] v,
                                                  input logic signed [31:0] lo,
                                                  input logic signed [31:0] hi);
        if (v < lo) return lo;
        if (v > hi) return hi;
        return v;
    endfunction

    logic signed [31:0] model_int;
    int unsigned        exp_samples;
    int unsigned        exp_sat;
    logic [DW-1:0]      exp_dac;
    bit                 dac_allow;

    // Per-cycle compare: no stray dac_valid, correct data while valid, data held while stalled.
    logic          prev_hold;
    logic [DW-1:0] prev_data;
    initial prev_hold = 1'b0;
    always @(negedge clk) begin
        if (rst_n) begin
            if (!dac_allow) chk("dac_valid_quiet", dac_valid, 0);
            else if (dac_valid) chk("dac_data_model", dac_data, exp_dac);
            if (prev_hold) chk("dac_data_hold", dac_data, prev_data);
            chk("adc_ready_during_dac", adc_ready & dac_valid, 0);
        end
        prev_hold <= rst_n && dac_valid && !dac_ready;
        prev_data <= dac_data;
    end

    task automatic check_zero(input string tag);
        chk({tag, "_adc_ready"}, adc_ready, 0);
        chk({tag, "_dac_valid"}, dac_valid, 0);
        chk({tag, "_dac_data"}, dac_data, 0);
        chk({tag, "_pipe_actual"}, pipe_actual, 0);
        chk({tag, "_integral"}, pipe_integral_input, 0);
        chk({tag, "_sample_count"}, sample_count, 0);
        chk({tag, "_sat_count"}, sat_count, 0);
        chk({tag, "_busy"}, busy, 0);
    endtask

    task automatic adc_handshake(input logic signed [IW-1:0] x, output bit ok);
        ok = 1'b0;
        adc_data  = x;
        adc_valid = 1'b1;
        for (int i = 0; i < 20; i++) begin
            if (adc_ready) begin
                ok = 1'b1;
                break;
            end
            @(posedge clk); #1;
        end
        chk("adc_ready_seen", ok, 1);
        if (ok) begin
            @(posedge clk); #1;
        end
        adc_valid = 1'b0;
        if (ok) chk("pipe_actual", pipe_actual, $unsigned(x));
    endtask

    // mode 0: normal, 1: integral_clear coincident with capture, 2: reset during DAC_WRITE
    task automatic run_sample(input logic signed [IW-1:0] x, input int stall, input int mode);
        logic signed [31:0] err, ires, pi, cl, new_int, old_int;
        bit ok;
        int k;
        err     = {{(32-IW){x[IW-1]}}, x};
        err     = err - setpoint;
        ires    = model_int + ki * err;
        pi      = kp * err + ires;
        cl      = clampf(pi, SLO, SHI);
        new_int = (mode == 1) ? 32'sd0 : clampf(ires, -IMAX, IMAX);
        old_int = model_int;
        exp_dac = cl[DW-1:0];
        adc_handshake(x, ok);
        if (!ok) return;
        dac_allow = 1'b1;
        ok = 1'b0;
        for (k = 1; k <= 20; k++) begin
            @(posedge clk); #1;
            if (k == PL) begin
                chk("integral_hold", pipe_integral_input, $unsigned(old_int));
                if (mode == 1) integral_clear = 1'b1;
            end
            if (k == PL + 1) integral_clear = 1'b0;
            if (dac_valid) begin
                ok = 1'b1;
                break;
            end
        end
        integral_clear = 1'b0;
        chk("dac_latency", k, PL + 2);
        chk("integral_after", pipe_integral_input, $unsigned(new_int));
        model_int = new_int;
        if (!ok) begin
            dac_allow = 1'b0;
            return;
        end
        if (mode == 2) begin
            rst_n = 1'b0;
            #1;
            dac_allow = 1'b0;
            check_zero("rst_in_dac");
            enable = 1'b0;
            repeat (3) @(posedge clk);
            #1;
            rst_n       = 1'b1;
            model_int   = 0;
            exp_samples = 0;
            exp_sat     = 0;
            return;
        end
        if (stall > 0) begin
            repeat (stall) @(posedge clk);
            #1;
            chk("dac_valid_stalled", dac_valid, 1);
            chk("adc_ready_stalled", adc_ready, 0);
        end
        dac_ready = 1'b1;
        @(posedge clk); #1;
        dac_ready = 1'b0;
        dac_allow = 1'b0;
        if (cl != pi) exp_sat++;
        exp_samples++;
        chk("dac_valid_after_hs", dac_valid, 0);
        chk("dac_data_after_hs", dac_data, exp_dac);
        chk("sample_count", sample_count, exp_samples);
        chk("sat_count", sat_count, exp_sat);
    endtask

    initial begin
        bit ok;
        rst_n = 1'b0; enable = 1'b0; integral_clear = 1'b0;
        adc_valid = 1'b0; adc_data = '0; dac_ready = 1'b0;
        kp = 0; ki = 0; setpoint = 0;
        model_int = 0; exp_samples = 0; exp_sat = 0; exp_dac = '0; dac_allow = 1'b0;
        #3;
        check_zero("reset");
        @(posedge clk); #1;
        rst_n  = 1'b1;
        enable = 1'b1;

        kp = 1; ki = 0; setpoint = 0;
        run_sample(18'sd100, 0, 0);
        chk("lit_kp1_dac", dac_data, 20'd100);
        chk("lit_kp1_count", sample_count, 32'd1);

        kp = 32'sh100000;
        run_sample(18'sd1, 0, 0);
        chk("lit_sat_hi_dac", dac_data, 20'h7FFFF);
        chk("lit_sat_hi_count", sat_count, 32'd1);
        kp = 1;
        run_sample(-18'sd5, 0, 0);
        chk("lit_neg_dac", dac_data, 20'hFFFFB);
        chk("lit_neg_sat", sat_count, 32'd1);

        kp = 2; setpoint = 40;
        run_sample(18'sd100, 0, 0);
        chk("lit_setpoint_dac", dac_data, 20'd120);
        setpoint = 0;

        kp = 0; ki = 1;
        run_sample(18'sd10, 10, 0);
        chk("lit_int1_dac", dac_data, 20'd10);
        chk("lit_int1_int", pipe_integral_input, 32'd10);
        run_sample(18'sd10, 0, 0);
        chk("lit_int2_dac", dac_data, 20'd20);
        chk("lit_int2_int", pipe_integral_input, 32'd20);
        run_sample(18'sd10, 0, 0);
        chk("lit_int3_dac", dac_data, 20'd30);
        chk("lit_int3_int", pipe_integral_input, 32'd25);
        run_sample(18'sd10, 0, 0);
        chk("lit_int4_dac", dac_data, 20'd35);
        chk("lit_int4_int", pipe_integral_input, 32'd25);

        // Abort in COMPUTE: no DAC write, integral untouched.
        adc_handshake(18'sd10, ok);
        repeat (3) @(posedge clk);
        #1;
        enable = 1'b0;
        @(posedge clk); #1;
        chk("abort_busy", busy, 0);
        chk("abort_dac_valid", dac_valid, 0);
        chk("abort_integral", pipe_integral_input, $unsigned(model_int));
        repeat (12) @(posedge clk);
        #1;
        chk("abort_samples", sample_count, exp_samples);
        enable = 1'b1;

        run_sample(18'sd10, 0, 1);
        chk("lit_clear_dac", dac_data, 20'd35);
        chk("lit_clear_int", pipe_integral_input, 32'd0);
        run_sample(18'sd10, 3, 0);
        chk("lit_post_clear_dac", dac_data, 20'd10);

        kp = 1; ki = 0;
        run_sample(18'sd7, 0, 2);
        repeat (15) @(posedge clk);
        #1;
        chk("post_reset_busy", busy, 0);
        chk("post_reset_samples", sample_count, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got running, expected finished");
        $fatal(1);
    end

endmodule
